// File: rtl/alu_share_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_ctrl_pkg
// Purpose  : Opcode map, flag bit positions and sequencer state encoding
//            shared by the ALU time-share controller.
// Revision : 1.0 - initial release
// ============================================================================
package alu_share_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;

  // Opcodes from here to 4'b1111 have no ALU meaning
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'b1100;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op >= OP_ILLEGAL_MIN);
  endfunction

  // Only ADD/SUB produce meaningful overflow and sign flags
  function automatic logic writes_vn(input logic [3:0] op);
    return (op[3:1] == 3'b000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_share_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_ctrl_if
// Purpose  : Request, ALU and response bundle of the ALU time-share controller.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_share_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [3:0]        req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [3:0]        req1_op;

  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [3:0]        alu_opcode;
  logic [DATA_W-1:0] alu_out;
  logic [2:0]        alu_zvn;
  logic              alu_fwe;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_port;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  logic [2:0]        flags;
  logic              busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output alu_in1, alu_in2, alu_opcode,
    input  alu_out, alu_zvn, alu_fwe,
    output rsp_valid, rsp_port, rsp_data, rsp_err,
    input  rsp_ready,
    output flags, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  alu_in1, alu_in2, alu_opcode,
    output alu_out, alu_zvn, alu_fwe,
    input  rsp_valid, rsp_port, rsp_data, rsp_err,
    output rsp_ready,
    input  flags, busy
  );

endinterface
`default_nettype wire

// File: rtl/alu_share_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-requester round-robin grant; the last-grant pointer only
//            moves when a grant is actually accepted.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt_valid,
  output logic       gnt_port
);

  logic r_last_grant;

  always_comb begin
    gnt_valid = |req;
    gnt_port  = 1'b0;
    if (req == 2'b11) begin
      gnt_port = ~r_last_grant;
    end else begin
      gnt_port = req[1];
    end
  end

  // Resets to port 1 so port 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (accept) begin
      r_last_grant <= gnt_port;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_ctrl
// Purpose  : Time-shares one 16-bit ALU between two requesters and owns the
//            architectural Z/V/N flag register.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  alu_share_ctrl_if.slave bus
);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [3:0]        r_op;
  logic              r_port;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic [2:0]        r_flags;

  logic              w_idle;
  logic              w_gnt_valid;
  logic              w_gnt_port;
  logic              w_accept;
  logic              w_illegal;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = w_idle & w_gnt_valid & ~rst;
  assign w_illegal = is_illegal_op(r_op);

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({bus.req1_valid, bus.req0_valid}),
    .accept    (w_accept),
    .gnt_valid (w_gnt_valid),
    .gnt_port  (w_gnt_port)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_port     <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_flags    <= '0;
    end else begin
      if (w_accept) begin
        r_port <= w_gnt_port;
        r_a    <= w_gnt_port ? bus.req1_a  : bus.req0_a;
        r_b    <= w_gnt_port ? bus.req1_b  : bus.req0_b;
        r_op   <= w_gnt_port ? bus.req1_op : bus.req0_op;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_data <= w_illegal ? '0 : bus.alu_out;
        r_rsp_err  <= w_illegal;
        // Z follows the ALU write enable; V/N additionally need ADD/SUB
        if (!w_illegal && bus.alu_fwe) begin
          r_flags[FLAG_Z] <= bus.alu_zvn[FLAG_Z];
          if (writes_vn(r_op)) begin
            r_flags[FLAG_V] <= bus.alu_zvn[FLAG_V];
            r_flags[FLAG_N] <= bus.alu_zvn[FLAG_N];
          end
        end
      end
    end
  end

  assign bus.req0_ready = w_accept & ~w_gnt_port;
  assign bus.req1_ready = w_accept &  w_gnt_port;

  assign bus.alu_in1    = r_a;
  assign bus.alu_in2    = r_b;
  assign bus.alu_opcode = r_op;

  assign bus.rsp_valid  = (r_state == ST_RESP);
  assign bus.rsp_port   = r_port;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_err    = r_rsp_err;

  assign bus.flags      = r_flags;
  assign bus.busy       = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_ctrl
// Purpose  : Directed self-checking bench for the ALU time-share controller,
//            with a small saturating ALU stand-in on the ALU side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_share_ctrl_if #(.DATA_W(16)) bus ();

  alu_share_ctrl #(.DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: V/N are deliberately set on non-arithmetic ops so that
  // any flag write the controller should mask shows up in the flags.
  function automatic logic [18:0] alu_ref(input logic [3:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    logic [16:0] ext;
    logic [15:0] r;
    logic        v;
    ext = '0;
    r   = '0;
    v   = 1'b0;
    case (op)
      4'b0000, 4'b0001: begin
        ext = (op == 4'b0000) ? ({a[15], a} + {b[15], b}) : ({a[15], a} - {b[15], b});
        if (ext[16] != ext[15]) begin
          v = 1'b1;
          r = ext[16] ? 16'h8000 : 16'h7FFF;
        end else begin
          r = ext[15:0];
        end
        return {(r == 16'h0000), v, r[15], r};
      end
      4'b0010: begin
        r = a ^ b;
        return {(r == 16'h0000), 1'b1, 1'b1, r};
      end
      default: begin
        r = a ^ b ^ 16'hA5A5;
        return {3'b111, r};
      end
    endcase
  endfunction

  assign {bus.alu_zvn, bus.alu_out} = alu_ref(bus.alu_opcode, bus.alu_in1, bus.alu_in2);
  assign bus.alu_fwe = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic port, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op);
    if (port) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
    end
  endtask

  // Called just after a falling edge; returns 1 ns later once a ready is seen
  task automatic wait_grant(output logic port);
    logic seen;
    seen = 1'b0;
    port = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        seen = 1'b1;
        port = bus.req1_ready;
        break;
      end
      @(negedge clk);
    end
    check_val("grant_seen", 32'(seen), 32'd1);
  endtask

  task automatic accept(output logic port);
    wait_grant(port);
    @(posedge clk);
    @(negedge clk);
    if (port) bus.req1_valid = 1'b0;
    else      bus.req0_valid = 1'b0;
  endtask

  task automatic get_rsp();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("rsp_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        g;
    logic [15:0] exp_data;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp_ready  = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_flags", 32'(bus.flags), 32'd0);
    check_val("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check_val("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
    check_val("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // ADD saturating: 0x7FFF + 1
    drive(1'b0, 16'h7FFF, 16'h0001, 4'b0000);
    accept(g);
    check_val("add_grant", 32'(g), 32'd0);
    check_val("add_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_val("add_exec_busy", 32'(bus.busy), 32'd1);
    check_val("add_exec_alu_in1", 32'(bus.alu_in1), 32'h7FFF);
    @(negedge clk);
    check_val("add_rsp_valid_t2", 32'(bus.rsp_valid), 32'd1);
    check_val("add_rsp_data", 32'(bus.rsp_data), 32'h7FFF);
    check_val("add_rsp_port", 32'(bus.rsp_port), 32'd0);
    check_val("add_rsp_err", 32'(bus.rsp_err), 32'd0);
    check_val("add_flags", 32'(bus.flags), 32'b010);
    @(negedge clk);
    check_val("add_idle_busy", 32'(bus.busy), 32'd0);

    // XOR to zero: Z set, V retained, N untouched
    drive(1'b1, 16'h00FF, 16'h00FF, 4'b0010);
    accept(g);
    get_rsp();
    check_val("xor_rsp_port", 32'(bus.rsp_port), 32'd1);
    check_val("xor_rsp_data", 32'(bus.rsp_data), 32'h0000);
    check_val("xor_flags", 32'(bus.flags), 32'b110);
    @(negedge clk);

    // Three simultaneous pairs: grants must alternate 0,1
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 16'h0100 + 16'(k), 16'h0001, 4'b0000);
      drive(1'b1, 16'h00F0, 16'(k + 1), 4'b0010);
      for (int j = 0; j < 2; j++) begin
        accept(g);
        check_val($sformatf("pair%0d_grant%0d", k, j), 32'(g), 32'(j));
        exp_data = (j == 0) ? (16'h0101 + 16'(k)) : (16'h00F0 ^ 16'(k + 1));
        get_rsp();
        check_val($sformatf("pair%0d_port%0d", k, j), 32'(bus.rsp_port), 32'(j));
        check_val($sformatf("pair%0d_data%0d", k, j), 32'(bus.rsp_data), 32'(exp_data));
        @(negedge clk);
      end
    end
    check_val("pair_flags", 32'(bus.flags), 32'b000);

    // Response back-pressure with a request pending on port 1
    bus.rsp_ready = 1'b0;
    drive(1'b0, 16'h1234, 16'h0001, 4'b0000);
    drive(1'b1, 16'h0F0F, 16'h00FF, 4'b0010);
    accept(g);
    check_val("hold_grant", 32'(g), 32'd0);
    get_rsp();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_val("hold_rsp_data", 32'(bus.rsp_data), 32'h1235);
      check_val("hold_req0_ready", 32'(bus.req0_ready), 32'd0);
      check_val("hold_req1_ready", 32'(bus.req1_ready), 32'd0);
      check_val("hold_busy", 32'(bus.busy), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check_val("release_busy", 32'(bus.busy), 32'd0);
    check_val("release_req1_ready", 32'(bus.req1_ready), 32'd1);
    accept(g);
    check_val("pending_grant", 32'(g), 32'd1);
    get_rsp();
    check_val("pending_rsp_data", 32'(bus.rsp_data), 32'h0FF0);
    @(negedge clk);

    // Set N via SUB 0 - 1, then an illegal opcode must not disturb it
    drive(1'b0, 16'h0000, 16'h0001, 4'b0001);
    accept(g);
    get_rsp();
    check_val("sub_rsp_data", 32'(bus.rsp_data), 32'hFFFF);
    check_val("sub_flags", 32'(bus.flags), 32'b001);
    @(negedge clk);
    drive(1'b0, 16'h0005, 16'h0006, 4'b1110);
    accept(g);
    get_rsp();
    check_val("illegal_rsp_err", 32'(bus.rsp_err), 32'd1);
    check_val("illegal_rsp_data", 32'(bus.rsp_data), 32'h0000);
    check_val("illegal_flags", 32'(bus.flags), 32'b001);
    @(negedge clk);

    // Asynchronous reset during EXEC of SUB 0 - 1
    drive(1'b0, 16'h0000, 16'h0001, 4'b0001);
    wait_grant(g);
    @(posedge clk);
    @(negedge clk);
    check_val("pre_rst_busy", 32'(bus.busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_val("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_val("arst_busy", 32'(bus.busy), 32'd0);
    check_val("arst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check_val("arst_flags", 32'(bus.flags), 32'd0);
    check_val("arst_alu_in2", 32'(bus.alu_in2), 32'd0);
    check_val("arst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
    check_val("arst_rsp_err", 32'(bus.rsp_err), 32'd0);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_val("post_rst_flags", 32'(bus.flags), 32'd0);
    end

    // After reset port 0 wins the first tie again
    drive(1'b0, 16'h0002, 16'h0003, 4'b0000);
    drive(1'b1, 16'h0002, 16'h0003, 4'b0010);
    accept(g);
    check_val("post_rst_tie_grant", 32'(g), 32'd0);
    get_rsp();
    check_val("post_rst_rsp_data", 32'(bus.rsp_data), 32'h0005);
    @(negedge clk);
    accept(g);
    get_rsp();
    check_val("post_rst_rsp2_data", 32'(bus.rsp_data), 32'h0001);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and two-way arbiter that time-shares the single 16-bit ALU between two requesters (pipeline execute path and the multi-cycle helper path). It accepts one operation at a time through a valid/ready handshake, drives the ALU from registered operands, captures the result, and owns the architectural Z/V/N flag register, applying the ALU's flag-write semantics per bit. The ALU itself is instantiated alongside this block; only its ports are wired here.

## Interface

- DATA_W, 16, operand/result width (only 16 is supported)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request pending on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  16  operands (held stable while valid)
- req0_op / req1_op  in  4  ALU opcode
- alu_in1, alu_in2  out  16  to ALU_In1, ALU_In2
- alu_opcode  out  4  to ALU Opcode
- alu_out  in  16  from ALU_Out
- alu_zvn  in  3  from ZVN ([2]=Z, [1]=V, [0]=N)
- alu_fwe  in  1  from FlagWriteEnable
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_port  out  1  requester the result belongs to
- rsp_data  out  16  result
- rsp_err  out  1  illegal opcode (4'b1100–4'b1111)
- flags  out  3  architectural Z/V/N register
- busy  out  1  state != IDLE

## Operation

- FSM states: IDLE, EXEC, RESP.
- IDLE: round-robin between req0/req1; single valid wins; both valid → port not granted last. last_grant resets to 1 (port 0 wins first tie). reqN_ready = (state==IDLE) & grant==N, combinational. On accept: latch a, b, op, port; → EXEC.
- EXEC (one cycle): alu_in1/alu_in2/alu_opcode driven from latched values (held at latched values in all states; 0 after reset). At end of cycle latch alu_out into rsp_data; → RESP.
- Flag update at end of EXEC, legal opcode only: Z ← alu_zvn[2] if alu_fwe; V,N ← alu_zvn[1:0] if alu_fwe & op[3:1]==3'b000. Other bits retain value. RED (0011), PADDSB (0111) and memory/load-byte ops (1xxx) never touch flags.
- Illegal opcode: still passes through EXEC; rsp_data=0, rsp_err=1, no flag write.
- RESP: rsp_valid=1, rsp_port/rsp_data/rsp_err stable until rsp_valid & rsp_ready; then → IDLE. No new request accepted in RESP (req ready low).
- Arithmetic is whatever the ALU returns (ADD/SUB saturating); no width change here.

## Timing

- Reset (async, any state): state=IDLE, all outputs 0 (rsp_valid, rsp_data, rsp_err, rsp_port, flags, alu_*, busy, reqN_ready stay 0 until reset deasserts), last_grant=1, in-flight operation discarded, no flag write.
- Accept at cycle T → EXEC at T+1 → rsp_valid high at T+2.
- rsp_ready high at T+2 → IDLE at T+3, next accept possible at T+3; max throughput 1 op / 3 cycles.
- rsp_ready low: RESP holds indefinitely; flags already updated at end of T+1.
- Request held valid while not granted stays pending; no drops, no starvation (worst wait one other op).

## Structure

- Shared package/header: opcode constants (ADD 0000 … LHB 1011), illegal-opcode range, flag bit indices Z=2/V=1/N=0, FSM state encoding.
- One sub-module: rr_arb2 (two-requester round-robin grant with last_grant register, update on accept only).

## Test plan

- req0 ADD 0x7FFF+0x0001 from reset → rsp_data=0x7FFF, rsp_port=0, rsp_valid at T+2, flags=3'b010.
- Then req1 XOR 0x00FF,0x00FF → rsp_data=0x0000, flags=3'b110 (Z set, V retained, N untouched).
- req0 and req1 valid same cycle, three back-to-back pairs → grants 0,1,0,1,0,1; each request served exactly once.
- rsp_ready held low 5 cycles after rsp_valid → rsp_data stable, both reqN_ready low, busy=1; release → IDLE next cycle.
- req0 op 4'b1110 with flags=3'b001 → rsp_err=1, rsp_data=0, flags remain 3'b001.
- Assert rst during EXEC of SUB 0x0000−0x0001 → all outputs 0 immediately, flags=0 after release, no rsp_valid emitted.
